glitc_control_regbank: RTL and testbench

Parametrised control/status register bank for the GLITC user-bus interface. It replaces the fixed two-read-only-plus-one-control register map with the following:
- a configurable number of 32-bit control registers;
- per-bit self-clearing pulse fields with programmable pulse length;
- per-register write strobes;
- a registered read path with an acknowledge.

It sits between the user-bus decoder and the clocking, reset and trigger-control logic, in the `user_clk_i` domain.

---
 rtl/glitc_control_regbank.sv | 145 ++++++++++++++
 tb/tb_glitc_control_regbank.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/glitc_control_regbank.sv
// GLITC user-bus control/status register bank: IDENT/VERSION words, NUM_CTRL control
// registers with self-clearing pulse bits, write strobes and a registered read path.
// Optional feature: define GLITC_CTRL_WRCOUNT_EN for a write counter at the top address.
module glitc_control_regbank #(
   parameter logic [31:0]            IDENT      = 32'h474C5443,
   parameter logic [31:0]            VERSION    = 32'h00000000,
   parameter int                     NUM_CTRL   = 4,
   parameter int                     ADDR_WIDTH = 3,
   parameter logic [NUM_CTRL*32-1:0] CTRL_INIT  = '0,
   parameter logic [31:0]            PULSE_MASK = 32'h80000000,
   parameter int                     PULSE_LEN  = 1
) (
   input  logic                     user_clk_i,
   input  logic                     user_rst_n_i,
   input  logic [ADDR_WIDTH-1:0]    user_addr_i,
   input  logic [31:0]              user_dat_i,
   output logic [31:0]              user_dat_o,
   input  logic                     user_wr_i,
   input  logic                     user_rd_i,
   input  logic                     user_sel_i,
   output logic                     user_ack_o,
   output logic [NUM_CTRL*32-1:0]   ctrl_o,
   output logic [NUM_CTRL-1:0]      ctrl_wr_o
);

   localparam logic [31:0]           PULSE_CLR  = ~PULSE_MASK;
   localparam logic [7:0]            PULSE_LOAD = 8'(PULSE_LEN);
   localparam logic [ADDR_WIDTH-1:0] CNT_ADDR   = '1;

   if (NUM_CTRL < 1 || NUM_CTRL > 62) begin : g_bad_num_ctrl
      $error("glitc_control_regbank: NUM_CTRL must be in 1..62");
   end
   if ((1 << ADDR_WIDTH) < NUM_CTRL + 2) begin : g_bad_addr_width
      $error("glitc_control_regbank: address space too small for NUM_CTRL");
   end
   if (PULSE_LEN < 1 || PULSE_LEN > 255) begin : g_bad_pulse_len
      $error("glitc_control_regbank: PULSE_LEN must be in 1..255");
   end
`ifdef GLITC_CTRL_WRCOUNT_EN
   if ((1 << ADDR_WIDTH) <= NUM_CTRL + 2) begin : g_bad_count_addr
      $error("glitc_control_regbank: write counter address collides with a control register");
   end
`endif

   // Bus handshake: an access is accepted on any rising edge where sel is high together with
   // wr and/or rd; there is no wait state, so every accepted access is acked exactly one cycle
   // later, and a combined wr+rd performs the write while returning the pre-write data.
   logic                access;
   logic                wr_acc;
   logic                rd_acc;
   logic [NUM_CTRL-1:0] hit;
   logic [31:0]         rd_data;
   logic [31:0]         ctrl_q [NUM_CTRL];
   logic [7:0]          cnt_q  [NUM_CTRL];

   assign wr_acc = user_sel_i && user_wr_i;
   assign rd_acc = user_sel_i && user_rd_i;
   assign access = wr_acc || rd_acc;

   always_comb begin
      hit = '0;
      for (int k = 0; k < NUM_CTRL; k++) begin
         hit[k] = wr_acc && (user_addr_i == ADDR_WIDTH'(k + 2));
      end
   end

`ifdef GLITC_CTRL_WRCOUNT_EN
   logic [31:0] wr_count_q;
   logic        count_clr;

   assign count_clr = wr_acc && (user_addr_i == CNT_ADDR);

   // Counts accepted control-register writes; saturates rather than wrapping.
   always_ff @(posedge user_clk_i) begin
      if (!user_rst_n_i) begin
         wr_count_q <= '0;
      end else if (count_clr) begin
         wr_count_q <= '0;
      end else if ((|hit) && (wr_count_q != 32'hFFFFFFFF)) begin
         wr_count_q <= wr_count_q + 32'd1;
      end
   end
`endif

   always_comb begin
      rd_data = '0;
      if (user_addr_i == ADDR_WIDTH'(0)) begin
         rd_data = IDENT;
      end else if (user_addr_i == ADDR_WIDTH'(1)) begin
         rd_data = VERSION;
      end
      for (int k = 0; k < NUM_CTRL; k++) begin
         if (user_addr_i == ADDR_WIDTH'(k + 2)) begin
            rd_data = ctrl_q[k];
         end
      end
`ifdef GLITC_CTRL_WRCOUNT_EN
      if (user_addr_i == CNT_ADDR) begin
         rd_data = wr_count_q;
      end
`endif
   end

   // One down-counter per register is shared by all of its pulse bits; the pulse bits
   // drop together on the edge where the counter steps from 1 to 0.
   always_ff @(posedge user_clk_i) begin
      if (!user_rst_n_i) begin
         for (int k = 0; k < NUM_CTRL; k++) begin
            ctrl_q[k] <= CTRL_INIT[32*k +: 32] & PULSE_CLR;
            cnt_q[k]  <= 8'd0;
         end
      end else begin
         for (int k = 0; k < NUM_CTRL; k++) begin
            if (hit[k]) begin
               ctrl_q[k] <= user_dat_i;
               cnt_q[k]  <= (|(user_dat_i & PULSE_MASK)) ? PULSE_LOAD : 8'd0;
            end else if (cnt_q[k] != 8'd0) begin
               cnt_q[k] <= cnt_q[k] - 8'd1;
               if (cnt_q[k] == 8'd1) begin
                  ctrl_q[k] <= ctrl_q[k] & PULSE_CLR;
               end
            end
         end
      end
   end

   always_ff @(posedge user_clk_i) begin
      if (!user_rst_n_i) begin
         user_ack_o <= 1'b0;
         ctrl_wr_o  <= '0;
         user_dat_o <= '0;
      end else begin
         user_ack_o <= access;
         ctrl_wr_o  <= hit;
         if (rd_acc) begin
            user_dat_o <= rd_data;
         end
      end
   end

   for (genvar k = 0; k < NUM_CTRL; k++) begin : g_ctrl_out
      assign ctrl_o[32*k +: 32] = ctrl_q[k];
   end

endmodule

// File: tb/tb_glitc_control_regbank.sv
// Self-checking bench for glitc_control_regbank with randomized traffic against a
// cycle-timestamp reference model (pulse bits tracked by expiry cycle, not by counters).
module tb_glitc_control_regbank;

   localparam logic [31:0]  IDENT   = 32'h474C5443;
   localparam logic [31:0]  VERSION = 32'h00000000;
   localparam logic [31:0]  PMASK   = 32'h80000000;
   localparam int           PLEN    = 4;
   localparam logic [127:0] INIT    = {32'h00000000, 32'h80001234, 32'h000000F0, 32'hFFFFFFFF};

   logic         clk;
   logic         rst_n;
   logic [2:0]   addr;
   logic [31:0]  dat_in;
   logic [31:0]  dat_out;
   logic         wr;
   logic         rd;
   logic         sel;
   logic         ack;
   logic [127:0] ctrl;
   logic [3:0]   ctrl_wr;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [31:0] m_reg [4];
   int          m_exp [4];
   logic [31:0] m_cnt;
   logic [31:0] e_dat;
   logic        e_ack;
   logic [3:0]  e_wr;

   glitc_control_regbank #(
      .IDENT(IDENT), .VERSION(VERSION), .NUM_CTRL(4), .ADDR_WIDTH(3),
      .CTRL_INIT(INIT), .PULSE_MASK(PMASK), .PULSE_LEN(PLEN)
   ) dut (
      .user_clk_i(clk), .user_rst_n_i(rst_n), .user_addr_i(addr), .user_dat_i(dat_in),
      .user_dat_o(dat_out), .user_wr_i(wr), .user_rd_i(rd), .user_sel_i(sel),
      .user_ack_o(ack), .ctrl_o(ctrl), .ctrl_wr_o(ctrl_wr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Value of register k as seen during cycle c: pulse bits only survive up to their expiry.
   function automatic logic [31:0] view(int k, int c);
      if (c <= m_exp[k]) return m_reg[k];
      return m_reg[k] & ~PMASK;
   endfunction

   function automatic logic [127:0] exp_ctrl(int c);
      logic [127:0] v;
      for (int k = 0; k < 4; k++) v[k*32 +: 32] = view(k, c);
      return v;
   endfunction

   function automatic logic [31:0] read_model(logic [2:0] a, int c);
      if (a == 3'd0) return IDENT;
      if (a == 3'd1) return VERSION;
      if (a >= 3'd2 && a <= 3'd5) return view(int'(a) - 2, c);
`ifdef GLITC_CTRL_WRCOUNT_EN
      if (a == 3'd7) return m_cnt;
`endif
      return 32'h0;
   endfunction

   task automatic step(input logic s, input logic w, input logic r, input logic [2:0] a,
                       input logic [31:0] d);
      logic [31:0] rv;
      int k;
      sel = s; wr = w; rd = r; addr = a; dat_in = d;
      rv = read_model(a, cyc);
      @(posedge clk); #1;
      cyc++;
      e_ack = s && (w || r);
      e_wr = 4'b0000;
      if (s && r) e_dat = rv;
      if (s && w) begin
         if (a >= 3'd2 && a <= 3'd5) begin
            k = int'(a) - 2;
            m_reg[k] = d;
            m_exp[k] = ((d & PMASK) != 32'h0) ? cyc + PLEN - 1 : cyc - 1;
            e_wr[k] = 1'b1;
            if (m_cnt != 32'hFFFFFFFF) m_cnt = m_cnt + 32'd1;
         end
`ifdef GLITC_CTRL_WRCOUNT_EN
         if (a == 3'd7) m_cnt = 32'h0;
`endif
      end
      sel = 1'b0; wr = 1'b0; rd = 1'b0;
   endtask

   task automatic do_reset(input logic s, input logic w, input logic [2:0] a, input logic [31:0] d);
      rst_n = 1'b0; sel = s; wr = w; rd = 1'b0; addr = a; dat_in = d;
      @(posedge clk); #1;
      cyc++;
      for (int k = 0; k < 4; k++) begin
         m_reg[k] = INIT[k*32 +: 32] & ~PMASK;
         m_exp[k] = 0;
      end
      m_cnt = 32'h0; e_dat = 32'h0; e_ack = 1'b0; e_wr = 4'b0000;
      rst_n = 1'b1; sel = 1'b0; wr = 1'b0;
   endtask

   task automatic test_reset();
      do_reset(1'b0, 1'b0, 3'd0, 32'h0);
      do_reset(1'b1, 1'b1, 3'd2, 32'hDEADBEEF);
      checks++; if (ctrl !== exp_ctrl(cyc)) begin errors++; $display("FAIL reset_ctrl got=%h exp=%h", ctrl, exp_ctrl(cyc)); end
      checks++; if (ctrl[63:32] !== 32'h000000F0) begin errors++; $display("FAIL reset_init_r1 got=%h exp=000000f0", ctrl[63:32]); end
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", ack); end
      checks++; if (ctrl_wr !== 4'b0000) begin errors++; $display("FAIL reset_ctrl_wr got=%b exp=0000", ctrl_wr); end
      checks++; if (dat_out !== 32'h0) begin errors++; $display("FAIL reset_dat got=%h exp=0", dat_out); end
   endtask

   task automatic test_ident();
      step(1'b1, 1'b0, 1'b1, 3'd0, 32'h0);
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL ident_ack got=%b exp=1", ack); end
      checks++; if (dat_out !== 32'h474C5443) begin errors++; $display("FAIL ident_dat got=%h exp=474c5443", dat_out); end
      step(1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL ident_ack_drop got=%b exp=0", ack); end
      checks++; if (dat_out !== 32'h474C5443) begin errors++; $display("FAIL ident_dat_hold got=%h exp=474c5443", dat_out); end
      step(1'b1, 1'b0, 1'b1, 3'd1, 32'h0);
      checks++; if (ack !== 1'b1 || dat_out !== 32'h0) begin errors++; $display("FAIL version_read ack=%b dat=%h exp ack=1 dat=0", ack, dat_out); end
   endtask

   task automatic test_write();
      step(1'b1, 1'b1, 1'b0, 3'd2, 32'h00000005);
      checks++; if (ctrl[2:0] !== 3'b101) begin errors++; $display("FAIL write_ctrl got=%b exp=101", ctrl[2:0]); end
      checks++; if (ctrl_wr !== 4'b0001 || ack !== 1'b1) begin errors++; $display("FAIL write_strobe wr=%b ack=%b exp wr=0001 ack=1", ctrl_wr, ack); end
      step(1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
      checks++; if (ctrl_wr !== 4'b0000) begin errors++; $display("FAIL write_strobe_drop got=%b exp=0000", ctrl_wr); end
      step(1'b1, 1'b0, 1'b1, 3'd2, 32'h0);
      checks++; if (dat_out !== 32'h00000005) begin errors++; $display("FAIL write_readback got=%h exp=00000005", dat_out); end
   endtask

   task automatic test_pulse();
      int high;
      step(1'b1, 1'b1, 1'b0, 3'd3, 32'h80000001);
      high = 0;
      for (int i = 0; i < 8; i++) begin
         if (ctrl[63]) high++;
         checks++; if (ctrl !== exp_ctrl(cyc)) begin errors++; $display("FAIL pulse_ctrl i=%0d got=%h exp=%h", i, ctrl, exp_ctrl(cyc)); end
         step(1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
      end
      checks++; if (high != 4) begin errors++; $display("FAIL pulse_len got=%0d exp=4", high); end
      checks++; if (ctrl[32] !== 1'b1) begin errors++; $display("FAIL pulse_static_bit got=%b exp=1", ctrl[32]); end
      step(1'b1, 1'b1, 1'b0, 3'd3, 32'h80000001);
      step(1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
      step(1'b1, 1'b1, 1'b0, 3'd3, 32'h80000001);
      high = 0;
      for (int i = 0; i < 8; i++) begin
         if (ctrl[63]) high++;
         checks++; if (ctrl !== exp_ctrl(cyc)) begin errors++; $display("FAIL pulse_rewrite_ctrl i=%0d got=%h exp=%h", i, ctrl, exp_ctrl(cyc)); end
         step(1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
      end
      checks++; if (high != 4) begin errors++; $display("FAIL pulse_rewrite_len got=%0d exp=4", high); end
      step(1'b1, 1'b1, 1'b0, 3'd3, 32'h80000000);
      step(1'b1, 1'b1, 1'b0, 3'd3, 32'h00000002);
      checks++; if (ctrl[63:32] !== 32'h00000002) begin errors++; $display("FAIL pulse_clear_now got=%h exp=00000002", ctrl[63:32]); end
   endtask

   task automatic test_rdwr();
      step(1'b1, 1'b1, 1'b0, 3'd2, 32'h00000005);
      step(1'b1, 1'b1, 1'b1, 3'd2, 32'hA5A5A5A5);
      checks++; if (dat_out !== 32'h00000005 || ack !== 1'b1) begin errors++; $display("FAIL rdwr_old dat=%h ack=%b exp dat=00000005 ack=1", dat_out, ack); end
      step(1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rdwr_single_ack got=%b exp=0", ack); end
      step(1'b1, 1'b0, 1'b1, 3'd2, 32'h0);
      checks++; if (dat_out !== 32'hA5A5A5A5) begin errors++; $display("FAIL rdwr_new got=%h exp=a5a5a5a5", dat_out); end
      step(1'b1, 1'b1, 1'b0, 3'd0, 32'h12345678);
      checks++; if (ctrl_wr !== 4'b0000 || ctrl !== exp_ctrl(cyc)) begin errors++; $display("FAIL ident_write_ignored wr=%b ctrl=%h", ctrl_wr, ctrl); end
      step(1'b1, 1'b0, 1'b1, 3'd0, 32'h0);
      checks++; if (dat_out !== IDENT) begin errors++; $display("FAIL ident_after_write got=%h exp=%h", dat_out, IDENT); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      d = $urandom() & ~PMASK;
      step(1'b1, 1'b1, 1'b0, 3'd4, d);
      checks++; if (ack !== 1'b1) begin errors++; $display("FAIL b2b_ack1 got=%b exp=1", ack); end
      step(1'b1, 1'b0, 1'b1, 3'd4, 32'h0);
      checks++; if (ack !== 1'b1 || dat_out !== d) begin errors++; $display("FAIL b2b_read ack=%b dat=%h exp ack=1 dat=%h", ack, dat_out, d); end
   endtask

   task automatic test_reset_mid();
      step(1'b1, 1'b1, 1'b0, 3'd5, 32'h80000010);
      step(1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
      do_reset(1'b1, 1'b1, 3'd5, 32'hFFFFFFFF);
      checks++; if (ctrl !== exp_ctrl(cyc)) begin errors++; $display("FAIL rstmid_ctrl got=%h exp=%h", ctrl, exp_ctrl(cyc)); end
      checks++; if (ack !== 1'b0 || ctrl_wr !== 4'b0000) begin errors++; $display("FAIL rstmid_bus ack=%b wr=%b exp ack=0 wr=0000", ack, ctrl_wr); end
      step(1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
      checks++; if (ctrl !== exp_ctrl(cyc) || ack !== 1'b0) begin errors++; $display("FAIL rstmid_after ctrl=%h ack=%b", ctrl, ack); end
   endtask

   task automatic test_wrcount();
      do_reset(1'b0, 1'b0, 3'd0, 32'h0);
      step(1'b1, 1'b1, 1'b0, 3'd2, 32'h1);
      step(1'b1, 1'b1, 1'b0, 3'd3, 32'h2);
      step(1'b1, 1'b1, 1'b0, 3'd5, 32'h3);
      step(1'b1, 1'b0, 1'b1, 3'd7, 32'h0);
      checks++; if (dat_out !== e_dat) begin errors++; $display("FAIL wrcount_read got=%h exp=%h", dat_out, e_dat); end
      step(1'b1, 1'b1, 1'b0, 3'd7, 32'h55);
      checks++; if (ctrl_wr !== 4'b0000 || ack !== 1'b1) begin errors++; $display("FAIL wrcount_clr_bus wr=%b ack=%b", ctrl_wr, ack); end
      step(1'b1, 1'b0, 1'b1, 3'd7, 32'h0);
      checks++; if (dat_out !== 32'h0) begin errors++; $display("FAIL wrcount_cleared got=%h exp=0", dat_out); end
      step(1'b1, 1'b0, 1'b1, 3'd6, 32'h0);
      checks++; if (dat_out !== 32'h0) begin errors++; $display("FAIL unmapped_read got=%h exp=0", dat_out); end
   endtask

   task automatic test_random();
      logic s, w, r;
      logic [2:0] a;
      logic [31:0] d;
      for (int i = 0; i < 300; i++) begin
         s = ($urandom_range(0, 3) != 0);
         w = $urandom_range(0, 1) != 0;
         r = $urandom_range(0, 1) != 0;
         a = 3'($urandom_range(0, 7));
         d = $urandom();
         if ($urandom_range(0, 1) == 0) d = d & ~PMASK;
         step(s, w, r, a, d);
         checks++; if (ack !== e_ack) begin errors++; $display("FAIL rand_ack i=%0d got=%b exp=%b", i, ack, e_ack); end
         checks++; if (ctrl_wr !== e_wr) begin errors++; $display("FAIL rand_ctrl_wr i=%0d got=%b exp=%b", i, ctrl_wr, e_wr); end
         checks++; if (dat_out !== e_dat) begin errors++; $display("FAIL rand_dat i=%0d got=%h exp=%h", i, dat_out, e_dat); end
         checks++; if (ctrl !== exp_ctrl(cyc)) begin errors++; $display("FAIL rand_ctrl i=%0d got=%h exp=%h", i, ctrl, exp_ctrl(cyc)); end
      end
   endtask

   initial begin
      rst_n = 1'b0; sel = 1'b0; wr = 1'b0; rd = 1'b0; addr = 3'd0; dat_in = 32'h0;
      m_cnt = 32'h0; e_dat = 32'h0; e_ack = 1'b0; e_wr = 4'b0000;
      for (int k = 0; k < 4; k++) begin m_reg[k] = 32'h0; m_exp[k] = 0; end
      test_reset();
      test_ident();
      test_write();
      test_pulse();
      test_rdwr();
      test_back_to_back();
      test_reset_mid();
      test_wrcount();
      test_random();
      test_wrcount();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
